reflet_int_to_float_seq: RTL and testbench

REFLET_INT_TO_FLOAT_SEQ -- requirements
Module: reflet_int_to_float_seq

---
 rtl/reflet_int_to_float_seq.sv | 124 ++++++++++++
 tb/tb_reflet_int_to_float_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reflet_int_to_float_seq.sv
// Sequential signed-integer to float converter: normalizes one bit per cycle,
// then presents {sign, biased exponent, truncated mantissa} under valid/ready.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | shifting abs left until its msb is set (or abs is zero)
// DONE  | float_out valid, held until out_ready
module reflet_int_to_float_seq #(
    parameter int int_size   = 16,
    parameter int float_size = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [int_size-1:0]   int_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [float_size-1:0] float_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    function automatic int exponent_size(input int fsize);
        case (fsize)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            128:     return 15;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int fsize);
        return fsize - exponent_size(fsize) - 1;
    endfunction

    function automatic int exponent_bias(input int fsize);
        return (1 << (exponent_size(fsize) - 1)) - 1;
    endfunction

    localparam int ES   = exponent_size(float_size);
    localparam int MS   = mantissa_size(float_size);
    localparam int BIAS = exponent_bias(float_size);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [int_size-1:0]     abs_q, abs_d;
    logic [ES-1:0]           exp_q, exp_d;
    logic [float_size-1:0]   float_out_q, float_out_d;
    logic [int_size-2+MS:0]  mant_ext;
    logic [MS-1:0]           mant;

    // Hidden bit dropped; the remaining fraction is left-aligned, then either
    // zero-padded or truncated (round toward zero) to the mantissa width.
    assign mant_ext = {abs_q[int_size-2:0], {MS{1'b0}}};
    assign mant     = MS'(mant_ext >> (int_size - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            abs_q       <= '0;
            exp_q       <= '0;
            float_out_q <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            abs_q       <= abs_d;
            exp_q       <= exp_d;
            float_out_q <= float_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = NORM;
            NORM:    if ((abs_q == '0) || abs_q[int_size-1]) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sign_d      = sign_q;
        abs_d       = abs_q;
        exp_d       = exp_q;
        float_out_d = float_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = int_in[int_size-1];
                    // Negating the most negative value wraps to 2^(n-1), which
                    // is exactly its magnitude read as unsigned.
                    abs_d  = int_in[int_size-1] ? -int_in : int_in;
                    exp_d  = ES'(BIAS + int_size - 1);
                end
            end
            NORM: begin
                if (abs_q == '0) begin
                    float_out_d = '0;
                end else if (!abs_q[int_size-1]) begin
                    abs_d = abs_q << 1;
                    exp_d = exp_q - ES'(1);
                end else begin
                    float_out_d = {sign_q, exp_q, mant};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        float_out = float_out_q;
    end

endmodule

// File: tb/tb_reflet_int_to_float_seq.sv
// Bench for reflet_int_to_float_seq: a latency/value model checked every cycle,
// directed literal cases, backpressure, mid-flight reset and random traffic.
module tb_reflet_int_to_float_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] int_in;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] float_out;

    logic [31:0] int_in32;
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] float_out32;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    reflet_int_to_float_seq #(.int_size(16), .float_size(32)) dut (
        .clk(clk), .reset(reset), .int_in(int_in), .in_valid(in_valid),
        .in_ready(in_ready), .float_out(float_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    reflet_int_to_float_seq #(.int_size(32), .float_size(32)) dut32 (
        .clk(clk), .reset(reset), .int_in(int_in32), .in_valid(in_valid32),
        .in_ready(in_ready32), .float_out(float_out32), .out_valid(out_valid32),
        .out_ready(out_ready32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Position of the highest set bit of a non-negative magnitude, -1 for zero.
    function automatic int msb_pos(input longint mag);
        int p;
        p = -1;
        for (int i = 0; i < 63; i++) if ((mag >> i) & 64'd1) p = i;
        return p;
    endfunction

    function automatic logic [31:0] model_f(input longint v);
        longint mag, rem, m;
        int p;
        logic [7:0] e;
        mag = (v < 0) ? -v : v;
        p = msb_pos(mag);
        if (p < 0) return 32'h0;
        e   = 8'(127 + p);
        rem = mag - (longint'(1) << p);
        m   = (p <= 23) ? (rem << (23 - p)) : (rem >> (p - 23));
        return {(v < 0) ? 1'b1 : 1'b0, e, 23'(m)};
    endfunction

    function automatic int model_lat(input longint v, input int n);
        longint mag;
        int p;
        mag = (v < 0) ? -v : v;
        p = msb_pos(mag);
        return (p < 0) ? 1 : 1 + (n - 1 - p);
    endfunction

    // Cycle model of the 16-bit instance: idle / busy-for-N-cycles / done.
    int          m_mode = 0;
    int          m_left = 0;
    bit          m_on = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] m_fo = '0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_on = 1'b1; m_mode = 0; m_fo = '0;
        end else if (m_on) begin
            case (m_mode)
                0: if (in_valid) begin
                    m_mode = 1;
                    m_left = model_lat(longint'($signed(int_in)), 16);
                    m_res  = model_f(longint'($signed(int_in)));
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 2; m_fo = m_res; end
                end
                default: if (out_ready) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("in_ready", 64'(in_ready), 64'(m_mode == 0));
            chk("out_valid", 64'(out_valid), 64'(m_mode == 2));
            chk("float_out", 64'(float_out), 64'(m_fo));
        end
    end

    task automatic run16(input logic [15:0] v, input logic [31:0] req_f, input int req_lat,
                         input int hold);
        int acc, n;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        in_valid = 1'b1; int_in = v; out_ready = 1'b0;
        @(negedge clk);
        acc = cyc; in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk("lit16_valid", 64'(out_valid), 64'd1);
        chk("lit16_value", 64'(float_out), 64'(req_f));
        chk("lit16_latency", 64'(cyc - acc), 64'(req_lat));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0]; int_in = 16'($urandom);
            @(negedge clk);
            chk("hold_value", 64'(float_out), 64'(req_f));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_done_idle", 64'(in_ready), 64'd1);
    endtask

    task automatic run32(input logic [31:0] v, input logic [31:0] req_f, input int req_lat);
        int acc, n;
        in_valid32 = 1'b1; int_in32 = v;
        @(negedge clk);
        acc = cyc; in_valid32 = 1'b0;
        n = 0;
        while (!out_valid32 && n < 60) begin @(negedge clk); n++; end
        chk("lit32_value", 64'(float_out32), 64'(req_f));
        chk("lit32_latency", 64'(cyc - acc), 64'(req_lat));
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual running required finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; int_in = '0; out_ready = 1'b0;
        in_valid32 = 1'b0; int_in32 = '0; out_ready32 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_float", 64'(float_out), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        chk("model_pin_1", 64'(model_f(64'sd1)), 64'h3F800000);
        chk("model_pin_7fff", 64'(model_f(64'sd32767)), 64'h46FFFE00);
        chk("model_pin_7fffffff", 64'(model_f(64'sd2147483647)), 64'h4EFFFFFF);

        run16(16'h0001, 32'h3F800000, 16, 0);
        run16(16'hFFFF, 32'hBF800000, 16, 0);
        run16(16'h0000, 32'h00000000, 1, 0);
        run16(16'h8000, 32'hC7000000, 1, 0);
        run16(16'h7FFF, 32'h46FFFE00, 2, 10);
        run16(16'h0003, 32'h40400000, 15, 0);

        in_valid = 1'b1; int_in = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; int_in = 16'h0007;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_float", 64'(float_out), 64'd0);
        run16(16'h0002, 32'h40000000, 15, 0);

        run32(32'h7FFFFFFF, 32'h4EFFFFFF, 2);
        run32(32'h80000000, 32'hCF000000, 1);
        run32(32'h00000001, 32'h3F800000, 32);

        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            int_in    = 16'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) int_in = -int_in;
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
